// File: rtl/hash_arbiter.sv
// Round-robin arbiter sharing one SHAKE core among N_REQ hash clients.
// Latches start pulses, launches the core with the winner's lengths and routes its traffic.
module hash_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req_hash_start,
  input  logic [N_REQ*32-1:0]   i_req_input_length,
  input  logic [N_REQ*32-1:0]   i_req_output_length,
  input  logic [N_REQ*32-1:0]   i_req_hash_data_in,
  output logic [ADDR_W-1:0]     o_req_hash_addr,
  output logic [N_REQ-1:0]      o_req_hash_rd_en,
  output logic [31:0]           o_req_hash_data_out,
  output logic [N_REQ-1:0]      o_req_hash_data_out_valid,
  input  logic [N_REQ-1:0]      i_req_hash_data_out_ready,
  input  logic [N_REQ-1:0]      i_req_hash_force_done,
  output logic [N_REQ-1:0]      o_req_hash_force_done_ack,
  output logic [N_REQ-1:0]      o_grant,
  output logic                  o_busy,
  output logic                  o_hash_start,
  output logic [31:0]           o_hash_input_length,
  output logic [31:0]           o_hash_output_length,
  output logic [31:0]           o_hash_data_in,
  input  logic [ADDR_W-1:0]     i_hash_addr,
  input  logic                  i_hash_rd_en,
  input  logic [31:0]           i_hash_data_out,
  input  logic                  i_hash_data_out_valid,
  output logic                  o_hash_data_out_ready,
  output logic                  o_hash_force_done,
  input  logic                  i_hash_force_done_ack
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RELEASE} state_t;

  state_t             state_reg, state_next;
  logic [N_REQ-1:0]   pending_reg, pending_next;
  logic [N_REQ-1:0]   grant_reg, grant_next;
  logic [IDX_W-1:0]   rr_reg, rr_next;
  logic [IDX_W-1:0]   gidx_reg, gidx_next;
  logic [31:0]        in_len_reg, in_len_next;
  logic [31:0]        out_len_reg, out_len_next;

  logic [N_REQ-1:0]   req;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  int                 scan_idx;
  logic               route_en;
  logic [31:0]        in_len_s  [N_REQ];
  logic [31:0]        out_len_s [N_REQ];
  logic [31:0]        data_s    [N_REQ];

  assign req      = pending_reg | i_req_hash_start;
  assign route_en = (state_reg != IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign in_len_s[gi]  = i_req_input_length[32*gi +: 32];
      assign out_len_s[gi] = i_req_output_length[32*gi +: 32];
      assign data_s[gi]    = i_req_hash_data_in[32*gi +: 32];
      assign o_req_hash_rd_en[gi] =
        route_en && (gidx_reg == IDX_W'(gi)) && i_hash_rd_en;
      assign o_req_hash_data_out_valid[gi] =
        route_en && (gidx_reg == IDX_W'(gi)) && i_hash_data_out_valid;
      assign o_req_hash_force_done_ack[gi] =
        (state_reg == RELEASE) && (gidx_reg == IDX_W'(gi)) && i_hash_force_done_ack;
    end
  endgenerate

  // First requester at or above the RR pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = int'(rr_reg) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(scan_idx);
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg | i_req_hash_start;
    grant_next   = grant_reg;
    gidx_next    = gidx_reg;
    rr_next      = rr_reg;
    in_len_next  = in_len_reg;
    out_len_next = out_len_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          grant_next            = N_REQ'(1) << win_idx;
          gidx_next             = win_idx;
          in_len_next           = in_len_s[win_idx];
          out_len_next          = out_len_s[win_idx];
          pending_next[win_idx] = 1'b0;
          rr_next    = (win_idx == IDX_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH:  state_next = BUSY;
      BUSY: begin
        if (i_req_hash_force_done[gidx_reg]) state_next = RELEASE;
      end
      RELEASE: begin
        if (i_hash_force_done_ack) begin
          state_next = IDLE;
          grant_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      grant_reg   <= '0;
      rr_reg      <= '0;
      gidx_reg    <= '0;
      in_len_reg  <= '0;
      out_len_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      grant_reg   <= grant_next;
      rr_reg      <= rr_next;
      gidx_reg    <= gidx_next;
      in_len_reg  <= in_len_next;
      out_len_reg <= out_len_next;
    end
  end

  assign o_grant               = grant_reg;
  assign o_busy                = route_en;
  assign o_hash_start          = (state_reg == LAUNCH);
  assign o_hash_force_done     = (state_reg == RELEASE);
  assign o_hash_input_length   = in_len_reg;
  assign o_hash_output_length  = out_len_reg;
  assign o_req_hash_addr       = i_hash_addr;
  assign o_req_hash_data_out   = i_hash_data_out;
  assign o_hash_data_in        = route_en ? data_s[gidx_reg] : 32'd0;
  assign o_hash_data_out_ready = route_en && i_req_hash_data_out_ready[gidx_reg];

endmodule
